// File: rtl/cg_rvarch_imm_stage_if.sv
// Handshake bundle for the immediate-decode stage.
// Stage takes the slave side; the fetch/register-read environment takes master.
interface cg_rvarch_imm_stage_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32
);
    logic                   i_flush;
    logic                   i_valid;
    logic                   o_ready;
    logic [INSTR_WIDTH-1:0] i_instr;
    logic                   o_valid;
    logic                   i_ready;
    logic [INSTR_WIDTH-1:0] o_instr;
    logic [DATA_WIDTH-1:0]  o_imm;
    logic [2:0]             o_fmt;
    logic                   o_illegal;

    modport slave (
        input  i_flush, i_valid, i_instr, i_ready,
        output o_ready, o_valid, o_instr, o_imm, o_fmt, o_illegal
    );

    modport master (
        output i_flush, i_valid, i_instr, i_ready,
        input  o_ready, o_valid, o_instr, o_imm, o_fmt, o_illegal
    );
endinterface

// File: rtl/cg_rvarch_imm_stage.sv
// RV32 immediate-decode stage: classify opcode, build sign-extended immediate,
// register it behind a 2-entry skid so o_ready never depends on i_ready.
module cg_rvarch_imm_stage #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    cg_rvarch_imm_stage_if.slave  bus
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [2:0] F_R   = 3'd0;
    localparam logic [2:0] F_I   = 3'd1;
    localparam logic [2:0] F_S   = 3'd2;
    localparam logic [2:0] F_B   = 3'd3;
    localparam logic [2:0] F_U   = 3'd4;
    localparam logic [2:0] F_J   = 3'd5;
    localparam logic [2:0] F_ILL = 3'd7;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0]  imm;
        logic [2:0]             fmt;
        logic                   ill;
    } ent_t;

    logic [31:0]           w_in;
    logic [2:0]            w_fmt;
    logic                  w_ill;
    logic [31:0]           w_imm32;
    ent_t                  w_dec;

    logic [1:0]            r_state;
    logic [1:0]            w_nstate;
    logic                  r_ready;
    ent_t                  r_out;
    ent_t                  r_skd;

    logic                  w_valid;
    logic                  w_acc;
    logic                  w_emit;
    logic                  w_ld_dec;
    logic                  w_ld_skd;
    logic                  w_skd_out;

    assign w_in = bus.i_instr[31:0];

    always_comb begin
        w_fmt   = F_R;
        w_ill   = 1'b0;
        w_imm32 = '0;
        unique case (w_in[6:0])
            7'b0110111, 7'b0010111: begin
                w_fmt   = F_U;
                w_imm32 = {w_in[31:12], 12'b0};
            end
            7'b1101111: begin
                w_fmt   = F_J;
                w_imm32 = {{11{w_in[31]}}, w_in[31], w_in[19:12],
                           w_in[20], w_in[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: begin
                w_fmt   = F_I;
                w_imm32 = {{20{w_in[31]}}, w_in[31:20]};
            end
            7'b0100011: begin
                w_fmt   = F_S;
                w_imm32 = {{20{w_in[31]}}, w_in[31:25], w_in[11:7]};
            end
            7'b1100011: begin
                w_fmt   = F_B;
                w_imm32 = {{19{w_in[31]}}, w_in[31], w_in[7],
                           w_in[30:25], w_in[11:8], 1'b0};
            end
            7'b0110011: w_fmt = F_R;
            default: begin
                w_fmt = F_ILL;
                w_ill = 1'b1;
            end
        endcase
    end

    assign w_dec.instr = bus.i_instr;
    assign w_dec.imm   = DATA_WIDTH'($signed(w_imm32));
    assign w_dec.fmt   = w_fmt;
    assign w_dec.ill   = w_ill;

    assign w_valid = (r_state != S_EMPTY);
    assign w_acc   = bus.i_valid & r_ready;
    assign w_emit  = w_valid & bus.i_ready;

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_EMPTY: if (w_acc) w_nstate = S_ONE;
            S_ONE: begin
                if (w_acc && !w_emit)      w_nstate = S_FULL;
                else if (!w_acc && w_emit) w_nstate = S_EMPTY;
            end
            S_FULL:  if (w_emit) w_nstate = S_ONE;
            default: w_nstate = S_EMPTY;
        endcase
        if (bus.i_flush) w_nstate = S_EMPTY;
    end

    // Flush wins over any load; stale data left in the registers is harmless.
    assign w_ld_dec  = !bus.i_flush & w_acc &
                       ((r_state == S_EMPTY) | ((r_state == S_ONE) & w_emit));
    assign w_ld_skd  = !bus.i_flush & w_acc & (r_state == S_ONE) & !w_emit;
    assign w_skd_out = !bus.i_flush & (r_state == S_FULL) & w_emit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b1;
            r_out   <= '0;
            r_skd   <= '0;
        end else begin
            r_state <= w_nstate;
            r_ready <= (w_nstate != S_FULL);
            if (w_ld_dec)       r_out <= w_dec;
            else if (w_skd_out) r_out <= r_skd;
            if (w_ld_skd)       r_skd <= w_dec;
        end
    end

    assign bus.o_ready   = r_ready;
    assign bus.o_valid   = w_valid;
    assign bus.o_instr   = r_out.instr;
    assign bus.o_imm     = r_out.imm;
    assign bus.o_fmt     = r_out.fmt;
    assign bus.o_illegal = r_out.ill;
endmodule

// File: tb/tb_cg_rvarch_imm_stage.sv
// Scoreboard bench for cg_rvarch_imm_stage: driver pushes expected entries,
// a negedge monitor pops and compares on every emitted entry.
module tb_cg_rvarch_imm_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cg_rvarch_imm_stage_if #(.INSTR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    cg_rvarch_imm_stage_if #(.INSTR_WIDTH(32), .DATA_WIDTH(64)) bus64 ();

    cg_rvarch_imm_stage #(.INSTR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    cg_rvarch_imm_stage #(.INSTR_WIDTH(32), .DATA_WIDTH(64)) dut64 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus64.slave)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t        e;
        logic        p_hold;
        logic [31:0] p_instr;
        logic [31:0] p_imm;
        logic [2:0]  p_fmt;
        logic        p_ill;
        p_hold = 1'b0;
        p_instr = '0; p_imm = '0; p_fmt = '0; p_ill = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_valid) begin
                if (p_hold) begin
                    chk("hold_instr", {32'h0, bus.o_instr}, {32'h0, p_instr});
                    chk("hold_imm", {32'h0, bus.o_imm}, {32'h0, p_imm});
                    chk("hold_fmt", {61'h0, bus.o_fmt}, {61'h0, p_fmt});
                    chk("hold_ill", {63'h0, bus.o_illegal}, {63'h0, p_ill});
                end
                if (bus.i_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %h want none",
                                 bus.o_instr);
                    end else begin
                        e = sb.pop_front();
                        chk("out_instr", {32'h0, bus.o_instr}, {32'h0, e.instr});
                        chk("out_imm", {32'h0, bus.o_imm}, {32'h0, e.imm[31:0]});
                        chk("out_fmt", {61'h0, bus.o_fmt}, {61'h0, e.fmt});
                        chk("out_ill", {63'h0, bus.o_illegal}, {63'h0, e.ill});
                    end
                end
            end
            p_hold  = rst_n && bus.o_valid && !bus.i_ready;
            p_instr = bus.o_instr;
            p_imm   = bus.o_imm;
            p_fmt   = bus.o_fmt;
            p_ill   = bus.o_illegal;
        end
    end

    task automatic send(input logic [31:0] ins, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic ill);
        exp_t e;
        int   n;
        e.instr = ins; e.imm = imm; e.fmt = fmt; e.ill = ill;
        bus.i_valid = 1'b1;
        bus.i_instr = ins;
        n = 0;
        @(negedge clk);
        while (!bus.o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got ready=0 want ready=1");
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_instr = '0;
        bus.i_ready = 1'b1;
        bus64.i_flush = 1'b0;
        bus64.i_valid = 1'b0;
        bus64.i_instr = '0;
        bus64.i_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_valid", {63'h0, bus.o_valid}, 64'h0);
        chk("rst_ready", {63'h0, bus.o_ready}, 64'h1);
        chk("rst_instr", {32'h0, bus.o_instr}, 64'h0);
        chk("rst_imm", {32'h0, bus.o_imm}, 64'h0);
        chk("rst_fmt", {61'h0, bus.o_fmt}, 64'h0);
        chk("rst_ill", {63'h0, bus.o_illegal}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("single_valid", {63'h0, bus.o_valid}, 64'h1);
        @(negedge clk);
        chk("single_gap", {63'h0, bus.o_valid}, 64'h0);
        @(posedge clk);
        #1;

        send(32'h12345037, 64'h12345000, 3'd4, 1'b0);
        send(32'h0080006F, 64'h00000008, 3'd5, 1'b0);
        send(32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 1'b0);
        send(32'h0020A223, 64'h00000004, 3'd2, 1'b0);
        send(32'h002081B3, 64'h00000000, 3'd0, 1'b0);
        send(32'h00008067, 64'h00000000, 3'd1, 1'b0);
        send(32'h80000037, 64'h80000000, 3'd4, 1'b0);
        send(32'h0000007F, 64'h00000000, 3'd7, 1'b1);
        send(32'h00000000, 64'h00000000, 3'd7, 1'b1);
        send(32'hFFF00013, 64'hFFFFFFFF, 3'd1, 1'b0);
        bus.i_valid = 1'b0;
        drain();

        bus.i_ready = 1'b0;
        send(32'h00A00113, 64'h0000000A, 3'd1, 1'b0);
        send(32'h00C000EF, 64'h0000000C, 3'd5, 1'b0);
        bus.i_valid = 1'b1;
        bus.i_instr = 32'h00000517;
        @(negedge clk);
        chk("full_ready", {63'h0, bus.o_ready}, 64'h0);
        chk("full_head", {32'h0, bus.o_instr}, 64'h00A00113);
        @(negedge clk);
        chk("full_ready2", {63'h0, bus.o_ready}, 64'h0);
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        send(32'h00000517, 64'h00000000, 3'd4, 1'b0);
        bus.i_valid = 1'b0;
        drain();

        bus.i_ready = 1'b0;
        send(32'h00100093, 64'h00000001, 3'd1, 1'b0);
        send(32'h00200093, 64'h00000002, 3'd1, 1'b0);
        bus.i_valid = 1'b1;
        bus.i_instr = 32'hDEAD0037;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        sb.delete();
        chk("flush_full_valid", {63'h0, bus.o_valid}, 64'h0);
        chk("flush_full_ready", {63'h0, bus.o_ready}, 64'h1);
        bus.i_ready = 1'b1;
        idle(3);

        bus.i_ready = 1'b0;
        send(32'h00300093, 64'h00000003, 3'd1, 1'b0);
        bus.i_instr = 32'hBEEF0037;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        sb.delete();
        chk("flush_one_valid", {63'h0, bus.o_valid}, 64'h0);
        chk("flush_one_ready", {63'h0, bus.o_ready}, 64'h1);
        bus.i_ready = 1'b1;
        idle(3);

        bus64.i_valid = 1'b1;
        bus64.i_instr = 32'h80000037;
        @(posedge clk);
        #1;
        bus64.i_instr = 32'hFFF00093;
        chk("w64_valid", {63'h0, bus64.o_valid}, 64'h1);
        chk("w64_imm_u", bus64.o_imm, 64'hFFFFFFFF80000000);
        chk("w64_fmt_u", {61'h0, bus64.o_fmt}, 64'h4);
        @(posedge clk);
        #1;
        bus64.i_valid = 1'b0;
        chk("w64_imm_i", bus64.o_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("w64_fmt_i", {61'h0, bus64.o_fmt}, 64'h1);
        idle(2);

        bus.i_ready = 1'b0;
        send(32'h00400093, 64'h00000004, 3'd1, 1'b0);
        send(32'h00500093, 64'h00000005, 3'd1, 1'b0);
        bus.i_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_valid", {63'h0, bus.o_valid}, 64'h0);
        chk("arst_ready", {63'h0, bus.o_ready}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        idle(2);
        chk("arst_after", {63'h0, bus.o_valid}, 64'h0);

        send(32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0);
        bus.i_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
